// File: rtl/id_ex_reg_pkg.sv
// Shared pipeline definitions: control-vector layout, ALU-op width and the bubble encoding.
package id_ex_reg_pkg;

    localparam int CTRL_W          = 6;
    localparam int CTRL_REG_WRITE  = 5;
    localparam int CTRL_MEM_READ   = 4;
    localparam int CTRL_MEM_WRITE  = 3;
    localparam int CTRL_MEM_TO_REG = 2;
    localparam int CTRL_ALU_SRC    = 1;
    localparam int CTRL_REG_DST    = 0;

    localparam int ALU_OP_W = 4;
    localparam logic [ALU_OP_W-1:0] BUBBLE_ALU_OP = 4'h0;

    typedef struct packed {
        logic                valid;
        logic [ALU_OP_W-1:0] alu_op;
        logic [CTRL_W-1:0]   ctrl;
    } slot_ctrl_t;

    // An invalid slot must never write registers or memory, so its control is squashed.
    function automatic slot_ctrl_t make_slot_ctrl(input logic valid,
                                                  input logic [ALU_OP_W-1:0] alu_op,
                                                  input logic [CTRL_W-1:0] ctrl);
        slot_ctrl_t s;
        s.valid  = valid;
        s.alu_op = valid ? alu_op : BUBBLE_ALU_OP;
        s.ctrl   = valid ? ctrl : '0;
        return s;
    endfunction

endpackage

// File: rtl/pipe_field_reg.sv
// Width-parameterised pipeline field register with priority reset > flush > stall > load.
module pipe_field_reg #(
    parameter int               W         = 8,
    parameter logic [W-1:0]     CLEAR_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         stall,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] q
);

    logic [W-1:0] field_q;
    logic [W-1:0] field_d;

    always_comb begin
        field_d = field_q;
        if (flush) begin
            field_d = CLEAR_VAL;
        end else if (!stall) begin
            field_d = load_val;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            field_q <= CLEAR_VAL;
        end else begin
            field_q <= field_d;
        end
    end

    assign q = field_q;

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: per-group field registers plus bubble/stall event counters.
module id_ex_reg
    import id_ex_reg_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int REG_IDX_W = 5,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 id_valid,
    input  logic [DATA_W-1:0]    id_pc,
    input  logic [DATA_W-1:0]    id_rs_data,
    input  logic [DATA_W-1:0]    id_rt_data,
    input  logic [DATA_W-1:0]    id_imm,
    input  logic [REG_IDX_W-1:0] id_rs,
    input  logic [REG_IDX_W-1:0] id_rt,
    input  logic [REG_IDX_W-1:0] id_rd,
    input  logic [ALU_OP_W-1:0]  id_alu_op,
    input  logic [CTRL_W-1:0]    id_ctrl,
    output logic                 ex_valid,
    output logic [DATA_W-1:0]    ex_pc,
    output logic [DATA_W-1:0]    ex_rs_data,
    output logic [DATA_W-1:0]    ex_rt_data,
    output logic [DATA_W-1:0]    ex_imm,
    output logic [REG_IDX_W-1:0] ex_rs,
    output logic [REG_IDX_W-1:0] ex_rt,
    output logic [REG_IDX_W-1:0] ex_rd,
    output logic [ALU_OP_W-1:0]  ex_alu_op,
    output logic [CTRL_W-1:0]    ex_ctrl,
    output logic [CNT_W-1:0]     bubble_cnt,
    output logic [CNT_W-1:0]     stall_cnt
);

    localparam int DATA_GRP_W = 4 * DATA_W;
    localparam int IDX_GRP_W  = 3 * REG_IDX_W;
    localparam int CTRL_GRP_W = $bits(slot_ctrl_t);
    localparam slot_ctrl_t BUBBLE_SLOT = '{valid: 1'b0, alu_op: BUBBLE_ALU_OP, ctrl: '0};

    logic [DATA_GRP_W-1:0] data_q;
    logic [IDX_GRP_W-1:0]  idx_q;
    slot_ctrl_t            slot_d;
    slot_ctrl_t            slot_q;

    assign slot_d = make_slot_ctrl(id_valid, id_alu_op, id_ctrl);

    pipe_field_reg #(.W(DATA_GRP_W)) u_data_reg (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .stall    (stall),
        .load_val ({id_pc, id_rs_data, id_rt_data, id_imm}),
        .q        (data_q)
    );

    pipe_field_reg #(.W(IDX_GRP_W)) u_idx_reg (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .stall    (stall),
        .load_val ({id_rs, id_rt, id_rd}),
        .q        (idx_q)
    );

    pipe_field_reg #(.W(CTRL_GRP_W), .CLEAR_VAL(BUBBLE_SLOT)) u_ctrl_reg (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .stall    (stall),
        .load_val (slot_d),
        .q        (slot_q)
    );

    assign {ex_pc, ex_rs_data, ex_rt_data, ex_imm} = data_q;
    assign {ex_rs, ex_rt, ex_rd}                   = idx_q;
    assign ex_valid  = slot_q.valid;
    assign ex_alu_op = slot_q.alu_op;
    assign ex_ctrl   = slot_q.ctrl;

    logic [CNT_W-1:0] bubble_cnt_q;
    logic [CNT_W-1:0] bubble_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    // Flush takes precedence, so a cycle with both asserted counts only as a bubble.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        if (flush) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end else if (stall) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg; a narrow-counter second instance covers counter wrap.
module tb_id_ex_reg;

    logic        clk = 1'b0;
    logic        reset, stall, flush, id_valid;
    logic [31:0] id_pc, id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [3:0]  id_alu_op;
    logic [5:0]  id_ctrl;

    logic        ex_valid;
    logic [31:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [3:0]  ex_alu_op;
    logic [5:0]  ex_ctrl;
    logic [31:0] bubble_cnt, stall_cnt;

    logic        n_valid;
    logic [31:0] n_pc, n_rs_data, n_rt_data, n_imm;
    logic [4:0]  n_rs, n_rt, n_rd;
    logic [3:0]  n_alu_op;
    logic [5:0]  n_ctrl;
    logic [3:0]  n_bubble_cnt, n_stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_reg dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_pc(id_pc), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_alu_op(id_alu_op), .id_ctrl(id_ctrl),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
        .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_alu_op(ex_alu_op),
        .ex_ctrl(ex_ctrl), .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
    );

    id_ex_reg #(.CNT_W(4)) dut_narrow (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_pc(id_pc), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_alu_op(id_alu_op), .id_ctrl(id_ctrl),
        .ex_valid(n_valid), .ex_pc(n_pc), .ex_rs_data(n_rs_data), .ex_rt_data(n_rt_data),
        .ex_imm(n_imm), .ex_rs(n_rs), .ex_rt(n_rt), .ex_rd(n_rd), .ex_alu_op(n_alu_op),
        .ex_ctrl(n_ctrl), .bubble_cnt(n_bubble_cnt), .stall_cnt(n_stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [3:0] op,
                         input logic [5:0] ctrl, input logic [4:0] rd);
        id_valid   = v;
        id_pc      = pc;
        id_rs_data = pc ^ 32'h1111_1111;
        id_rt_data = pc ^ 32'h2222_2222;
        id_imm     = pc + 32'h4;
        id_rs      = rd + 5'd1;
        id_rt      = rd + 5'd2;
        id_rd      = rd;
        id_alu_op  = op;
        id_ctrl    = ctrl;
    endtask

    task automatic check_loaded(input string tag, input logic [31:0] pc, input logic [3:0] op,
                                input logic [5:0] ctrl, input logic [4:0] rd);
        check({tag, "_valid"},  {31'd0, ex_valid}, 32'd1);
        check({tag, "_pc"},     ex_pc, pc);
        check({tag, "_rs_data"}, ex_rs_data, pc ^ 32'h1111_1111);
        check({tag, "_rt_data"}, ex_rt_data, pc ^ 32'h2222_2222);
        check({tag, "_imm"},    ex_imm, pc + 32'h4);
        check({tag, "_idx"},    {17'd0, ex_rs, ex_rt, ex_rd},
              {17'd0, rd + 5'd1, rd + 5'd2, rd});
        check({tag, "_alu_op"}, {28'd0, ex_alu_op}, {28'd0, op});
        check({tag, "_ctrl"},   {26'd0, ex_ctrl}, {26'd0, ctrl});
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, {31'd0, ex_valid}, 32'd0);
        check({tag, "_pc"},    ex_pc, 32'd0);
        check({tag, "_data"},  ex_rs_data | ex_rt_data | ex_imm, 32'd0);
        check({tag, "_idx"},   {17'd0, ex_rs, ex_rt, ex_rd}, 32'd0);
        check({tag, "_alu_op"}, {28'd0, ex_alu_op}, 32'd0);
        check({tag, "_ctrl"},  {26'd0, ex_ctrl}, 32'd0);
    endtask

    // Invalid EX slot must never carry control.
    always @(negedge clk) begin
        if (ex_valid === 1'b0) begin
            check("inv_ctrl", {26'd0, ex_ctrl}, 32'd0);
            check("inv_alu_op", {28'd0, ex_alu_op}, 32'd0);
        end
    end

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        drive(1'b1, 32'hDEAD_BEEF, 4'hA, 6'b111111, 5'd17);

        // 1: reset for two cycles with live ID inputs
        step(); step();
        check_zero("rst");
        check("rst_bubble_cnt", bubble_cnt, 32'd0);
        check("rst_stall_cnt", stall_cnt, 32'd0);

        // 2: plain load appears one cycle later
        reset = 1'b0;
        drive(1'b1, 32'h0040_0010, 4'h5, 6'b100011, 5'd3);
        step();
        check_loaded("load", 32'h0040_0010, 4'h5, 6'b100011, 5'd3);

        // 3: three stall cycles with changing ID inputs
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h0000_1000 + i, 4'h7 + 4'(i), 6'b010101, 5'd20 + 5'(i));
            step();
            check_loaded("stall_hold", 32'h0040_0010, 4'h5, 6'b100011, 5'd3);
        end
        check("stall_cnt3", stall_cnt, 32'd3);
        check("stall_bubble0", bubble_cnt, 32'd0);
        stall = 1'b0;
        drive(1'b1, 32'h0040_0020, 4'h2, 6'b110110, 5'd7);
        step();
        check_loaded("release", 32'h0040_0020, 4'h2, 6'b110110, 5'd7);

        // 4: flush and stall together -> bubble wins
        flush = 1'b1; stall = 1'b1;
        drive(1'b1, 32'h0040_0024, 4'h3, 6'b100001, 5'd9);
        step();
        check_zero("flush");
        check("flush_bubble_cnt", bubble_cnt, 32'd1);
        check("flush_stall_cnt", stall_cnt, 32'd3);

        // 5: invalid ID slot squashes control but still loads data
        flush = 1'b0; stall = 1'b0;
        drive(1'b0, 32'h0000_0500, 4'hF, 6'b111111, 5'd9);
        step();
        check("inv_valid", {31'd0, ex_valid}, 32'd0);
        check("inv_ex_ctrl", {26'd0, ex_ctrl}, 32'd0);
        check("inv_ex_alu", {28'd0, ex_alu_op}, 32'd0);
        check("inv_pc", ex_pc, 32'h0000_0500);
        check("inv_rd", {27'd0, ex_rd}, 32'd9);
        check("inv_bubble_cnt", bubble_cnt, 32'd1);

        // 6: counter wrap on the 4-bit instance (3 -> 15 -> 0)
        stall = 1'b1;
        for (int i = 0; i < 12; i++) step();
        check("narrow_stall15", {28'd0, n_stall_cnt}, 32'd15);
        check("wide_stall15", stall_cnt, 32'd15);
        step();
        check("narrow_wrap", {28'd0, n_stall_cnt}, 32'd0);
        check("wide_stall16", stall_cnt, 32'd16);
        check("narrow_bubble", {28'd0, n_bubble_cnt}, 32'd1);

        // reset while stalled and flushing clears everything
        reset = 1'b1; flush = 1'b1;
        step();
        check_zero("rst_mid");
        check("rst_mid_bubble", bubble_cnt, 32'd0);
        check("rst_mid_stall", stall_cnt, 32'd0);
        check("rst_mid_narrow", {28'd0, n_stall_cnt}, 32'd0);

        // first load after reset behaves normally
        reset = 1'b0; flush = 1'b0; stall = 1'b0;
        drive(1'b1, 32'h0040_0100, 4'h9, 6'b001110, 5'd31);
        step();
        check_loaded("post_rst", 32'h0040_0100, 4'h9, 6'b001110, 5'd31);
        check("post_rst_cnts", bubble_cnt | stall_cnt, 32'd0);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
